// File: rtl/sap1_datapath_if.sv
// Bundles the SAP-1 datapath control, program-load and observation signals
// so that the control unit (or a bench) and the datapath connect through one port.
interface sap1_datapath_if #(
    parameter int ADDR_W = 4
);
    // Handshake semantics: there is no valid/ready pair. The datapath
    // samples cword on every sysclk rising edge and only acts on it when
    // clken=1. prog_we is a single-edge write strobe that does not depend on
    // clken. All outputs are either registered (ir, out_reg, carry) or
    // purely combinational from current state and cword (bus, bus_conflict).
    logic              clken;
    logic [11:0]       cword;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_data;
    logic [7:0]        ir;
    logic [7:0]        out_reg;
    logic [7:0]        bus;
    logic              carry;
    logic              bus_conflict;

    // Controller side: drives control and program-load signals
    modport master (
        output clken, cword, prog_we, prog_addr, prog_data,
        input  ir, out_reg, bus, carry, bus_conflict
    );

    // Datapath side
    modport slave (
        input  clken, cword, prog_we, prog_addr, prog_data,
        output ir, out_reg, bus, carry, bus_conflict
    );
endinterface

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, IR, A, B, output register, ALU, program RAM and
// a single priority-muxed internal bus with conflict detection.
module sap1_datapath #(
    parameter int ADDR_W = 4
) (
    input  logic            sysclk,
    input  logic            clear_n,
    sap1_datapath_if.slave  dp_if
);
    localparam int DEPTH = 1 << ADDR_W;

    // Architectural state
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [7:0]        r_ir;
    logic [7:0]        r_a;
    logic [7:0]        r_b;
    logic [7:0]        r_out;
    logic              r_carry;
    logic [7:0]        r_ram [0:DEPTH-1];

    // Control word decode, MSB first
    logic w_pc_en, w_pc_inc, w_mar_ld, w_ir_en, w_ir_ld, w_mem_en;
    logic w_a_en, w_a_ld, w_b_ld, w_alu_en, w_o_ld, w_sub;

    assign w_pc_en  = dp_if.cword[11];
    assign w_pc_inc = dp_if.cword[10];
    assign w_mar_ld = dp_if.cword[9];
    assign w_ir_en  = dp_if.cword[8];
    assign w_ir_ld  = dp_if.cword[7];
    assign w_mem_en = dp_if.cword[6];
    assign w_a_en   = dp_if.cword[5];
    assign w_a_ld   = dp_if.cword[4];
    assign w_b_ld   = dp_if.cword[3];
    assign w_alu_en = dp_if.cword[2];
    assign w_o_ld   = dp_if.cword[1];
    assign w_sub    = dp_if.cword[0];

    // ALU: subtraction is A + ~B + 1, so bit 8 is carry for add and
    // "no borrow" for subtract.
    logic [7:0] w_b_op;
    logic [8:0] w_alu_sum;

    assign w_b_op    = w_sub ? ~r_b : r_b;
    assign w_alu_sum = {1'b0, r_a} + {1'b0, w_b_op} + {8'd0, w_sub};

    // Asynchronous RAM read addressed by MAR
    logic [7:0] w_mem_rd;
    assign w_mem_rd = r_ram[r_mar];

    // Bus source mux, fixed priority PC > IR > MEM > A > ALU, idle value zero
    logic [7:0] w_bus;
    always_comb begin
        w_bus = 8'h00;
        if (w_pc_en)
            w_bus = 8'(r_pc);
        else if (w_ir_en)
            w_bus = 8'(r_ir[ADDR_W-1:0]);
        else if (w_mem_en)
            w_bus = w_mem_rd;
        else if (w_a_en)
            w_bus = r_a;
        else if (w_alu_en)
            w_bus = w_alu_sum[7:0];
    end

    // Conflict whenever two or more drivers are enabled at once
    logic [2:0] w_drv_cnt;
    assign w_drv_cnt = {2'b00, w_pc_en} + {2'b00, w_ir_en} + {2'b00, w_mem_en}
                     + {2'b00, w_a_en} + {2'b00, w_alu_en};

    // Register file update; every load sees the pre-edge bus value, so
    // combinations like ALU_EN|A_LD or PC_EN|PC_INC behave as read-then-write.
    always_ff @(posedge sysclk or negedge clear_n) begin
        if (!clear_n) begin
            r_pc    <= '0;
            r_mar   <= '0;
            r_ir    <= 8'h00;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_out   <= 8'h00;
            r_carry <= 1'b0;
        end else if (dp_if.clken) begin
            if (w_pc_inc) r_pc  <= r_pc + ADDR_W'(1);
            if (w_mar_ld) r_mar <= w_bus[ADDR_W-1:0];
            if (w_ir_ld)  r_ir  <= w_bus;
            if (w_a_ld)   r_a   <= w_bus;
            if (w_b_ld)   r_b   <= w_bus;
            if (w_o_ld)   r_out <= w_bus;
            if (w_alu_en && w_a_ld) r_carry <= w_alu_sum[8];
        end
    end

    // Program RAM write port; contents survive reset but writes are
    // blocked while clear_n is low.
    always_ff @(posedge sysclk) begin
        if (clear_n && dp_if.prog_we)
            r_ram[dp_if.prog_addr] <= dp_if.prog_data;
    end

    assign dp_if.ir           = r_ir;
    assign dp_if.out_reg      = r_out;
    assign dp_if.bus          = w_bus;
    assign dp_if.carry        = r_carry;
    assign dp_if.bus_conflict = (w_drv_cnt > 3'd1);
endmodule

// File: doc/sap1_datapath.md
SAP1_DATAPATH -- requirements
Module: sap1_datapath

Interface
REQ-001 Parameter: ADDR_W, default 4, address width; RAM depth is 2^ADDR_W words of 8 bits.
REQ-002 sysclk  input  1  system clock; all state changes on the rising edge.
REQ-003 clear_n  input  1  reset, asynchronous and active-low.
REQ-004 clken  input  1  datapath clock enable; register loads occur only on edges where clken=1.
REQ-005 cword  input  12  control word, bit 11 to bit 0: PC_EN, PC_INC, MAR_LD, IR_EN, IR_LD, MEM_EN, A_EN, A_LD, B_LD, ALU_EN, O_LD, SUB.
REQ-006 prog_we  input  1  RAM program-write strobe.
REQ-007 prog_addr  input  ADDR_W  RAM program-write address.
REQ-008 prog_data  input  8  RAM program-write data.
REQ-009 ir  output  8  instruction register; feeds the control unit.
REQ-010 out_reg  output  8  output register.
REQ-011 bus  output  8  current internal bus value; combinational.
REQ-012 carry  output  1  registered ALU carry/borrow flag.
REQ-013 bus_conflict  output  1  combinational; high when more than one bus driver enable is asserted.

Function
REQ-014 The bus drivers SHALL be PC_EN, IR_EN, MEM_EN, A_EN and ALU_EN, with sources as follows:
- PC_EN: zero-extended PC.
- IR_EN: zero-extended ir[ADDR_W-1:0].
- MEM_EN: RAM[MAR].
- A_EN: A.
- ALU_EN: ALU result.
REQ-015 With no driver enabled, bus SHALL be 8'h00.
REQ-016 With multiple drivers enabled, bus SHALL take the highest-priority source (PC > IR > MEM > A > ALU) and bus_conflict SHALL be 1.
REQ-017 ALU result SHALL be A+B when SUB=0 and A+~B+1 when SUB=1, truncated to 8 bits; the 9th bit is the carry-out.
REQ-018 On a rising edge with clken=1:
- MAR_LD loads bus[ADDR_W-1:0] into MAR.
- IR_LD loads bus into IR.
- A_LD loads bus into A.
- B_LD loads bus into B.
- O_LD loads bus into out_reg.
REQ-019 On a rising edge with clken=1 and PC_INC=1, PC SHALL increment modulo 2^ADDR_W (15 -> 0 at ADDR_W=4).
REQ-020 Simultaneous PC_EN and PC_INC: bus SHALL carry the pre-increment PC, and PC increments.
REQ-021 Simultaneous ALU_EN and A_LD: A SHALL receive the result computed from the pre-edge A and B.
REQ-022 Simultaneous loads of several registers from one bus value SHALL all take effect in the same edge.
REQ-023 carry SHALL update with the ALU carry-out only on edges where clken=1, ALU_EN=1 and A_LD=1; otherwise it holds.
REQ-024 With clken=0, all registers SHALL hold regardless of cword.
REQ-025 cword=12'h000 SHALL change no register.
REQ-026 prog_we=1 on a rising edge SHALL write prog_data to RAM[prog_addr], independent of clken.
REQ-027 A same-edge prog_we write and MEM_EN read of the same address: the bus SHALL show old data in that cycle and the new data afterward.
REQ-028 RAM reads SHALL be combinational (asynchronous) from MAR.

Reset
REQ-029 While clear_n=0:
- PC, MAR, IR, A, B, out_reg and carry SHALL be 0 immediately, without waiting for sysclk.
- bus_conflict follows cword combinationally.
REQ-030 RAM contents SHALL NOT be affected by reset.
REQ-031 prog_we writes SHALL be ignored while clear_n=0.
REQ-032 Reset asserted mid-instruction SHALL abort the instruction; the first edge after clear_n rises with clken=1 acts on the current cword from zeroed registers.

Verification
REQ-033 Load/out scenario:
- Stimulus: program RAM[9]=8'h1C, IR=8'h09; apply IR_EN|MAR_LD, then MEM_EN|A_LD, then A_EN|O_LD, each with clken=1.
- Response: out_reg=8'h1C, carry=0.
REQ-034 Add with carry:
- Stimulus: A=8'hF0, B=8'h20, cword ALU_EN|A_LD.
- Response: A=8'h10, carry=1.
- Then with SUB set, A=8'h05, B=8'h07: A=8'hFE, carry=0.
REQ-035 Fetch and PC wrap:
- Stimulus: PC=15, cword PC_EN|PC_INC|MAR_LD.
- Response: MAR=15, PC=0, bus=8'h0F during the cycle.
REQ-036 Gating and conflict:
- Stimulus: clken=0 with cword 12'hFFF.
- Response: no register changes, bus=zero-extended PC, bus_conflict=1.
REQ-037 Reset mid-operation:
- Stimulus: clear_n pulsed low between edges while A=8'h33 and PC=7.
- Response: A=0 and PC=0 immediately, and RAM[9] still 8'h1C.
